sdrd_byte_assembler: RTL

- Downstream consumer of the SDRD serial-read bit emitted by the window-read sequence engine.
- Each qualifying bus read of the window (SSER low, BA13 low, BA12 high, BR_W high) produces one SDRD bit.
- This block samples those bits, assembles them LSB-first into bytes and queues them in a small FIFO.
- The host side drains the FIFO over a valid/ready handshake; the block also flags overruns and stalled (timed-out) partial bytes.

---
 rtl/sdrd_byte_assembler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sdrd_byte_assembler.sv
// sdrd_byte_assembler: samples SDRD serial-read bits on each qualifying window
// read, assembles them LSB-first into BYTE_W-bit words and queues the words in
// a small FIFO drained by a valid/ready consumer. Flags dropped words (sticky
// overrun) and partial words abandoned after an idle timeout (frame_err pulse).
module sdrd_byte_assembler #(
  parameter int BYTE_W       = 8,
  parameter int FIFO_DEPTH   = 2,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_strobe,
  input  logic                      sdrd,
  input  logic                      sync_clr,
  output logic [BYTE_W-1:0]         byte_data,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic [$clog2(BYTE_W)-1:0] bit_cnt,
  output logic                      busy,
  output logic                      overrun,
  output logic                      frame_err
);

  localparam int CNT_W = $clog2(BYTE_W);
  localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state;
  logic [BYTE_W-1:0] shift_reg;
  logic [BYTE_W-1:0] word_next;
  logic [TO_W-1:0]   to_cnt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [BYTE_W-1:0] mem [FIFO_DEPTH];

  logic last_bit;
  logic push;
  logic pop;
  logic timeout;
  logic fifo_empty;
  logic fifo_full;
  logic do_write;
  logic drop;

  // Word as it will look once the current sdrd bit lands at position bit_cnt.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    word_next          = shift_reg;
    word_next[bit_cnt] = sdrd;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign last_bit = (state == ST_SHIFT) && (bit_cnt == CNT_W'(BYTE_W - 1));
  assign push     = rd_strobe & last_bit & ~sync_clr;
  assign pop      = byte_valid & byte_ready & ~sync_clr;
  assign timeout  = (state == ST_SHIFT) && !rd_strobe && (to_cnt == TO_W'(IDLE_TIMEOUT));
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_write = push & (~fifo_full | pop);
  assign drop     = push & fifo_full & ~pop;

  assign byte_valid = ~fifo_empty;
  // An empty FIFO presents zero so the output is defined without resetting mem.
  assign byte_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  assign busy       = (state == ST_SHIFT);

  // Bit-assembly state machine with idle timeout and frame_err pulse.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else if (sync_clr) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (rd_strobe) begin
            shift_reg <= {{(BYTE_W-1){1'b0}}, sdrd};
            bit_cnt   <= CNT_W'(1);
            state     <= ST_SHIFT;
          end
        end
        default: begin
          if (rd_strobe) begin
            to_cnt <= '0;
            if (last_bit) begin
              shift_reg <= '0;
              bit_cnt   <= '0;
              state     <= ST_IDLE;
            end else begin
              shift_reg <= word_next;
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end
          end else if (timeout) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
      endcase
    end
  end

  // FIFO pointers and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else if (sync_clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (drop)     overrun <= 1'b1;
    end
  end

  // FIFO storage; contents are only observed through a non-empty read pointer.
  // NOTE: the memory array has no reset; the pointers alone define its validity.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[PTR_W-1:0]] <= word_next;
  end

endmodule
